// File: rtl/add_seq_pkg.sv
// Shared widths, state encoding and payload types for the add_sequencer slice.
package add_seq_pkg;

   localparam int unsigned OPW              = 33;
   localparam int unsigned SUMW             = 34;
   localparam int unsigned ADDER_BIT_CYCLES = 66;
   localparam int unsigned STW              = 3;

   typedef enum logic [STW-1:0] {
      FLUSH = 3'd0,
      ACKF  = 3'd1,
      IDLE  = 3'd2,
      REQ   = 3'd3,
      WAIT  = 3'd4,
      ACK   = 3'd5
   } state_e;

   // Plain-vector views of the states for the legacy-style state register.
   localparam logic [STW-1:0] ST_FLUSH = FLUSH;
   localparam logic [STW-1:0] ST_ACKF  = ACKF;
   localparam logic [STW-1:0] ST_IDLE  = IDLE;
   localparam logic [STW-1:0] ST_REQ   = REQ;
   localparam logic [STW-1:0] ST_WAIT  = WAIT;
   localparam logic [STW-1:0] ST_ACK   = ACK;

   typedef struct packed {
      logic [OPW-1:0] a;
      logic [OPW-1:0] b;
   } operands_t;

   // States whose single cycle is a start_add pulse (request or acknowledge).
   function automatic logic pulse_state(input logic [STW-1:0] s);
      return (s == ST_ACKF) || (s == ST_REQ) || (s == ST_ACK);
   endfunction

endpackage

// File: rtl/add_seq_if.sv
// Upstream operand, adder handshake and downstream result signals of add_sequencer.
interface add_seq_if;
   import add_seq_pkg::*;

   logic            in_valid;
   logic            in_ready;
   logic [OPW-1:0]  in_a;
   logic [OPW-1:0]  in_b;
   logic [OPW-1:0]  A;
   logic [OPW-1:0]  B;
   logic            start_add;
   logic            finish_add;
   logic [SUMW-1:0] S;
   logic            out_valid;
   logic            out_ready;
   logic [SUMW-1:0] out_sum;
   logic            busy;

   modport master (
      input  in_valid, in_a, in_b, finish_add, S, out_ready,
      output in_ready, A, B, start_add, out_valid, out_sum, busy
   );

   modport slave (
      output in_valid, in_a, in_b, finish_add, S, out_ready,
      input  in_ready, A, B, start_add, out_valid, out_sum, busy
   );

endinterface

// File: rtl/add_seq_outbuf.sv
// One-entry valid/ready result register; a load wins over a simultaneous pop.
module add_seq_outbuf
   import add_seq_pkg::*;
(
   input  logic            clock,
   input  logic            reset,
   input  logic            load,
   input  logic [SUMW-1:0] data,
   input  logic            ready,
   output logic            valid,
   output logic [SUMW-1:0] sum,
   output logic            valid_nxt_c
);

   always_comb begin
      valid_nxt_c = load | (valid & ~ready);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         valid <= 1'b0;
         sum   <= '0;
      end else begin
         valid <= valid_nxt_c;
         if (load) begin
            sum <= data;
         end
      end
   end

endmodule

// File: rtl/add_sequencer.sv
// Operand-side initiator for the bit-serial adder: absorbs the post-reset run,
// issues request/acknowledge pulses and buffers results. Option: ADD_SEQ_TIMEOUT_EN.
module add_sequencer
   import add_seq_pkg::*;
#(
   parameter int unsigned MAX_WAIT = 80
) (
   input  logic      clock,
   input  logic      reset,
   add_seq_if.master bus
`ifdef ADD_SEQ_TIMEOUT_EN
   ,
   output logic      timeout_err
`endif
);

   // A timeout shorter than one adder run, or beyond the 7-bit counter, can never be right.
   if (MAX_WAIT <= ADDER_BIT_CYCLES || MAX_WAIT > 127) begin : g_max_wait_check
      $error("add_sequencer: MAX_WAIT out of range");
   end

   logic [STW-1:0]  state_q;
   logic [STW-1:0]  state_d;
   operands_t       ops_q;
   logic            start_q;
   logic            in_ready_q;
   logic            busy_q;
   logic            accept_c;
   logic            load_c;
   logic            out_valid;
   logic            valid_nxt_c;
   logic [SUMW-1:0] out_sum;

   always_comb begin
      state_d  = state_q;
      accept_c = 1'b0;
      load_c   = 1'b0;
      case (state_q)
         ST_FLUSH: if (bus.finish_add) state_d = ST_ACKF;
         ST_ACKF:  state_d = ST_IDLE;
         ST_IDLE: begin
            if (bus.in_valid) begin
               accept_c = 1'b1;
               state_d  = ST_REQ;
            end
         end
         ST_REQ:   state_d = ST_WAIT;
         ST_WAIT: begin
            // The adder holds its finish state while the buffer is blocked.
            if (bus.finish_add && (!out_valid || bus.out_ready)) begin
               load_c  = 1'b1;
               state_d = ST_ACK;
            end
         end
         ST_ACK:   state_d = ST_IDLE;
         default:  state_d = ST_FLUSH;
      endcase
   end

   // Outputs are registered from the next state so they line up with it.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= ST_FLUSH;
         ops_q      <= '0;
         start_q    <= 1'b0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         state_q    <= state_d;
         if (accept_c) begin
            ops_q <= '{a: bus.in_a, b: bus.in_b};
         end
         start_q    <= pulse_state(state_d);
         in_ready_q <= (state_d == ST_IDLE);
         busy_q     <= (state_d != ST_IDLE) || valid_nxt_c;
      end
   end

   add_seq_outbuf u_outbuf (
      .clock       (clock),
      .reset       (reset),
      .load        (load_c),
      .data        (bus.S),
      .ready       (bus.out_ready),
      .valid       (out_valid),
      .sum         (out_sum),
      .valid_nxt_c (valid_nxt_c)
   );

   assign bus.A         = ops_q.a;
   assign bus.B         = ops_q.b;
   assign bus.start_add = start_q;
   assign bus.in_ready  = in_ready_q;
   assign bus.busy      = busy_q;
   assign bus.out_valid = out_valid;
   assign bus.out_sum   = out_sum;

`ifdef ADD_SEQ_TIMEOUT_EN
   localparam int unsigned TOW = 7;

   logic [TOW-1:0] wait_cnt_q;
   logic           counting_c;
   logic           timeout_q;

   // Only an adder that is genuinely still running counts; a blocked finish does not.
   always_comb begin
      counting_c = ((state_q == ST_FLUSH) || (state_q == ST_WAIT)) && !bus.finish_add;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         wait_cnt_q <= '0;
         timeout_q  <= 1'b0;
      end else begin
         if ((state_d == ST_WAIT) && (state_q != ST_WAIT)) begin
            wait_cnt_q <= '0;
         end else if (counting_c && (wait_cnt_q != '1)) begin
            wait_cnt_q <= wait_cnt_q + TOW'(1);
         end
         if (counting_c && (wait_cnt_q == TOW'(MAX_WAIT - 1))) begin
            timeout_q <= 1'b1;
         end
      end
   end

   assign timeout_err = timeout_q;
`endif

endmodule

// File: tb/tb_add_sequencer.sv
// Directed bench for add_sequencer with a behavioural bit-serial adder and a result scoreboard.
module tb_add_sequencer;
   import add_seq_pkg::*;

   localparam int unsigned    MAX_WAIT = 80;
   localparam logic [SUMW-1:0] JUNK    = 34'h2_AAAA_5555;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   add_seq_if bus();

`ifdef ADD_SEQ_TIMEOUT_EN
   logic timeout_err;
`endif

   add_sequencer #(.MAX_WAIT(MAX_WAIT)) dut (
      .clock       (clock),
      .reset       (reset),
      .bus         (bus)
`ifdef ADD_SEQ_TIMEOUT_EN
      ,
      .timeout_err (timeout_err)
`endif
   );

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;
   int unsigned cyc      = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   always @(posedge clock) cyc <= cyc + 1;

   // Adder: self-starts on reset, runs 66 cycles, holds finish until acknowledged.
   logic        running;
   logic        stall = 1'b0;
   int unsigned run_cnt;

   always @(posedge clock) begin
      if (reset) begin
         running        <= 1'b1;
         run_cnt        <= 0;
         bus.finish_add <= 1'b0;
         bus.S          <= JUNK;
      end else if (bus.start_add && bus.finish_add) begin
         bus.finish_add <= 1'b0;
      end else if (bus.start_add && !running) begin
         running <= 1'b1;
         run_cnt <= 0;
         bus.S   <= SUMW'(bus.A) + SUMW'(bus.B);
      end else if (running && !stall) begin
         if (run_cnt == ADDER_BIT_CYCLES - 1) begin
            running        <= 1'b0;
            bus.finish_add <= 1'b1;
         end else begin
            run_cnt <= run_cnt + 1;
         end
      end
   end

   // Scoreboard: results leave in order, exactly as the sum of accepted operands.
   logic [SUMW-1:0] exp_q[$];
   logic [OPW-1:0]  exp_a, exp_b;
   logic            prev_start, pend_req;
   int unsigned     acc_cyc;

   always @(negedge clock) begin
      #1;
      if (reset) begin
         exp_q.delete();
         exp_a      = '0;
         exp_b      = '0;
         prev_start = 1'b0;
         pend_req   = 1'b0;
      end else begin
         check("busy_rule", bus.busy, !bus.in_ready || bus.out_valid);
         check("op_a", bus.A, exp_a);
         check("op_b", bus.B, exp_b);
         check("start_single_cycle", bus.start_add && prev_start, 0);
         if (bus.start_add && !bus.finish_add) begin
            check("req_expected", pend_req, 1);
            check("req_cycle", cyc, acc_cyc + 1);
            check("req_adder_ready", running, 0);
            pend_req = 1'b0;
         end
         if (bus.out_valid) begin
            check("result_pending", exp_q.size() != 0, 1);
            if (exp_q.size() != 0) begin
               check("out_sum", bus.out_sum, exp_q[0]);
               if (bus.out_ready) void'(exp_q.pop_front());
            end
         end
         if (bus.in_valid && bus.in_ready) begin
            exp_q.push_back(SUMW'(bus.in_a) + SUMW'(bus.in_b));
            exp_a    = bus.in_a;
            exp_b    = bus.in_b;
            pend_req = 1'b1;
            acc_cyc  = cyc;
         end
         prev_start = bus.start_add;
      end
   end

   task automatic check_reset_values();
      check("rst_A", bus.A, 0);
      check("rst_B", bus.B, 0);
      check("rst_start_add", bus.start_add, 0);
      check("rst_in_ready", bus.in_ready, 0);
      check("rst_out_valid", bus.out_valid, 0);
      check("rst_out_sum", bus.out_sum, 0);
      check("rst_busy", bus.busy, 1);
`ifdef ADD_SEQ_TIMEOUT_EN
      check("rst_timeout_err", timeout_err, 0);
`endif
   endtask

   // Reset, then follow the flush: one acknowledge pulse, IDLE 68 cycles later.
   task automatic do_reset();
      int unsigned k;
      int unsigned pulses;
      @(negedge clock);
      reset        = 1'b1;
      bus.in_valid = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      check_reset_values();
      reset  = 1'b0;
      pulses = 0;
      for (k = 0; k < 200 && !bus.in_ready; k++) begin
         check("flush_busy", bus.busy, 1);
         if (bus.start_add) begin
            pulses++;
            check("flush_ack_finish", bus.finish_add, 1);
         end
         @(negedge clock);
      end
      check("flush_idle", bus.in_ready, 1);
      check("flush_idle_cycle", k, 68);
      check("flush_pulses", pulses, 1);
      check("flush_no_result", bus.out_valid, 0);
   endtask

   // Offer one job; when timed, pin the T+1 / T+68 / T+69 / T+70 milestones.
   task automatic run_job(input logic [OPW-1:0] a, input logic [OPW-1:0] b,
                          input logic [SUMW-1:0] exp_sum, input bit timed);
      int unsigned k;
      for (k = 0; k < 300 && !bus.in_ready; k++) @(negedge clock);
      check("accept_ready", bus.in_ready, 1);
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_valid = 1'b1;
      @(negedge clock);
      bus.in_valid = 1'b0;
      check("req_pulse", bus.start_add, 1);
      check("req_not_ready", bus.in_ready, 0);
      if (timed) begin
         repeat (67) @(negedge clock);
         check("pre_result_valid", bus.out_valid, 0);
         check("finish_seen", bus.finish_add, 1);
         @(negedge clock);
         check("result_valid", bus.out_valid, 1);
         check("result_sum", bus.out_sum, exp_sum);
         check("ack_pulse", bus.start_add, 1);
         @(negedge clock);
         check("idle_again", bus.in_ready, 1);
         check("valid_after_ack", bus.out_valid, !bus.out_ready);
      end
   endtask

   initial begin
      int unsigned pulses;
      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b1;

      do_reset();

      run_job(33'd5, 33'd7, 34'd12, 1'b1);
      run_job(33'h1_FFFF_FFFF, 33'h0_0000_0001, 34'h2_0000_0000, 1'b1);

      // Blocked buffer: second job waits in finish until the first result drains.
      bus.out_ready = 1'b0;
      run_job(33'd1, 33'd2, 34'd3, 1'b1);
      run_job(33'd3, 33'd4, 34'd7, 1'b0);
      pulses = 0;
      repeat (75) begin
         @(negedge clock);
         if (bus.start_add) pulses++;
      end
      check("stall_no_ack", pulses, 0);
      check("stall_finish_held", bus.finish_add, 1);
      check("stall_valid", bus.out_valid, 1);
      check("stall_sum", bus.out_sum, 34'd3);
      check("stall_not_ready", bus.in_ready, 0);
      bus.out_ready = 1'b1;
      @(negedge clock);
      check("reload_valid", bus.out_valid, 1);
      check("reload_sum", bus.out_sum, 34'd7);
      check("reload_ack", bus.start_add, 1);
      @(negedge clock);
      check("drain_valid", bus.out_valid, 0);
      check("drain_idle", bus.in_ready, 1);

      // Reset in the middle of a job: the job is lost and the flush repeats.
      run_job(33'd9, 33'd10, 34'd19, 1'b0);
      repeat (29) @(negedge clock);
      do_reset();
      run_job(33'd11, 33'd12, 34'd23, 1'b1);

`ifdef ADD_SEQ_TIMEOUT_EN
      check("no_timeout_normal", timeout_err, 0);
      stall = 1'b1;
      run_job(33'd1, 33'd1, 34'd2, 1'b0);
      repeat (80) @(negedge clock);
      check("timeout_before", timeout_err, 0);
      @(negedge clock);
      check("timeout_set", timeout_err, 1);
      repeat (10) @(negedge clock);
      check("timeout_sticky", timeout_err, 1);
      check("timeout_state_held", bus.in_ready, 0);
      check("timeout_no_pulse", bus.start_add, 0);
      stall = 1'b0;
      do_reset();
`endif

      repeat (3) @(negedge clock);
      check("final_queue_empty", exp_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got cycle %0d, required completion", cyc);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/add_sequencer.md
# add_sequencer

Operand-side initiator for the bit-serial adder FSM (start_add/finish_add handshake, 33-bit A/B, 34-bit S). It accepts operand pairs from a valid/ready upstream and drives A, B and start_add into the adder. It collects S on finish_add and returns it through a one-entry valid/ready result buffer. It also absorbs the adder's spurious operation after reset, so downstream logic never observes it.

## Interface
- MAX_WAIT, default 80: cycles allowed in FLUSH/WAIT before timeout. Used only with ADD_SEQ_TIMEOUT_EN.
- clock  in  1  system clock; all logic on rising edge
- reset  in  1  synchronous, active-high; shared net with the adder
- in_valid  in  1  operand pair offered
- in_ready  out  1  high only in IDLE
- in_a, in_b  in  33 each  operands
- A, B  out  33 each  registered operands to adder; stable from accept until next accept
- start_add  out  1  registered single-cycle pulses only
- finish_add  in  1  adder done flag
- S  in  34  adder result
- out_valid  out  1  result buffer full
- out_ready  in  1  downstream accepts
- out_sum  out  34  buffered result
- busy  out  1  state != IDLE or out_valid
- timeout_err  out  1  sticky timeout flag; present only with ADD_SEQ_TIMEOUT_EN

## Operation
- start_add is always a one-cycle pulse:
  - pulse with finish_add=0 is a request; the adder must be in its start state.
  - pulse with finish_add=1 is an acknowledge.
  - start_add is never held high for two consecutive cycles.
- States:
  - FLUSH (reset): start_add=0. The adder self-starts on reset. On finish_add=1 go to ACKF.
  - ACKF: start_add=1, S discarded, then IDLE.
  - IDLE: in_ready=1. On in_valid, latch in_a/in_b into A/B, then REQ.
  - REQ: start_add=1, then WAIT.
  - WAIT: start_add=0. On finish_add=1 with out_valid=0 (or out_ready=1 this cycle), load out_sum<=S, set out_valid, then ACK. If the buffer is full and not draining, stay in WAIT; the adder holds its finish state indefinitely.
  - ACK: start_add=1, then IDLE.
- REQ is never entered while finish_add=1. IDLE follows ACK by one cycle, so finish_add has already cleared.
- out_valid clears on out_valid&out_ready unless reloaded in the same cycle; a simultaneous pop and load yields out_valid=1 with the new data.
- Arithmetic: no extension or modification; out_sum is exactly S[33:0].
- Reset values: A=0, B=0, start_add=0, in_ready=0, out_valid=0, out_sum=0, busy=1, timeout_err=0, state=FLUSH.
- Reset mid-operation: the in-flight job and buffered result are lost and FLUSH repeats. No out_valid until a new job completes.

## Timing
- Accept edge ends IDLE cycle T.
- REQ occupies cycle T+1.
- The adder runs 66 cycles (33 bits × ADD/RES).
- finish_add is seen in T+68.
- ACK occupies T+69, with out_valid=1 from T+69.
- IDLE is re-entered at T+70.
- Back-to-back throughput: one job per 70 cycles.
- Post-reset flush: ACKF occurs about 67 cycles after reset deasserts; IDLE follows at the next cycle.

## Configuration
- ADD_SEQ_TIMEOUT_EN defined:
  - 7-bit cycle counter cleared on entry to FLUSH/WAIT, counting while there with finish_add=0.
  - Reaching MAX_WAIT sets timeout_err (sticky until reset); the state is unchanged.
  - The WAIT hold caused by a full buffer does not count.
- ADD_SEQ_TIMEOUT_EN undefined: no counter, no timeout_err port, identical handshake behaviour.

## Structure
- Package add_seq_pkg holds:
  - OPW=33, SUMW=34
  - ADDER_BIT_CYCLES=66
  - state enum: FLUSH, ACKF, IDLE, REQ, WAIT, ACK
- One sub-module, add_seq_outbuf: the one-entry valid/ready result register with simultaneous load/pop.
- The FSM and start_add pulse generation stay in the top module.

## Test plan
- Reset with in_valid=0 against the real adder: in_ready=0 and busy=1 until FLUSH ends; exactly one start_add pulse while finish_add=1; out_valid stays 0; IDLE about 68 cycles after reset.
- in_a=5, in_b=7 accepted at T: single REQ pulse at T+1; out_sum=34'd12 with out_valid at T+69; ACK pulse at T+69.
- in_a=33'h1_FFFF_FFFF, in_b=33'h0_0000_0001: out_sum=34'h2_0000_0000.
- out_ready=0, jobs (1,2) then (3,4): result 3 is held; the second job stays in WAIT with finish_add=1 and no ACK pulse. Raising out_ready pops 3; 7 loads the same cycle and is delivered next, in order.
- Reset asserted 30 cycles into a job: all outputs take their reset values next edge; the flush repeats; no stale out_valid.
- With ADD_SEQ_TIMEOUT_EN and a stub adder that never raises finish_add: timeout_err=1 after MAX_WAIT=80 cycles in WAIT, sticky until reset.
